alu_acc_4b: RTL and testbench
=============================

# alu_acc_4b

Sequential accumulator stage directly downstream of the 4-bit adder/subtractor datapath. It accepts one opcode/operand command per valid/ready handshake and applies it to a 4-bit accumulator: LOAD, ADD, SUB, or a multi-cycle MUL by repeated addition. All arithmetic goes through one `adder_4b` instance. Results and flags are presented on a valid/ready output port to the ALU control/display logic.

## Interface
Parameters: none (width fixed at 4).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  command valid
- in_ready  out  1  block can accept a command; 1 only in IDLE
- in_op  in  2  opcode: 00 LOAD, 01 ADD, 10 SUB, 11 MUL
- in_operand  in  4  unsigned/two's-complement operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_acc  out  4  accumulator value (registered)
- out_carry  out  1  carry / no-borrow flag (only with ALU_ACC_FLAGS_EN)
- out_zero  out  1  out_acc == 0 (only with ALU_ACC_FLAGS_EN)
- out_ovf  out  1  signed overflow (only with ALU_ACC_FLAGS_EN)

## Operation
- States: IDLE, MUL_LOOP, RESP.
- IDLE: in_ready=1. A command is accepted when in_valid & in_ready.
  - LOAD: acc<=operand; carry=0, ovf=0; go to RESP.
  - ADD: acc<=acc+operand via adder_4b (cin=0); carry=adder cout; ovf=(a3==b3)&(s3!=a3); go to RESP.
  - SUB: acc<=acc+~operand+1 via adder_4b (cin=1); carry=adder cout (1 = no borrow); ovf=(a3!=b3)&(s3!=a3); go to RESP. Do not use subtractor_4b, whose cout is tied to 0.
  - MUL: mcand<=acc, count<=operand, prod<=0, mul_c<=0; go to MUL_LOOP.
- MUL_LOOP: if count==0, then acc<=prod, carry<=mul_c, ovf<=0, go to RESP. Else prod<=prod+mcand (adder_4b), mul_c<=mul_c|cout, count<=count-1. The result is unsigned modulo 16, and carry flags unsigned overflow.
- RESP: out_valid=1. out_acc and flags are held stable until out_valid & out_ready; then go to IDLE.
- out_zero is registered alongside acc.
- The adder input mux selects (acc, operand) in IDLE and (prod, mcand) in MUL_LOOP.

## Timing
- Reset values: state=IDLE, acc=0, out_acc=0, out_valid=0, in_ready=1, carry=0, zero=0, ovf=0, count=0, prod=0.
- LOAD/ADD/SUB: accept at edge T; out_valid=1 from T+1.
- MUL with operand n: out_valid from T+n+2 (n adds plus 1 writeback cycle); n=0 gives acc=0 at T+2.
- in_ready=0 from the accept edge until the cycle after the output handshake. There is no back-to-back acceptance, and input and output handshakes never coincide.
- The output handshake in RESP returns to IDLE on the next cycle; a new command is accepted no earlier than that.
- Backpressure has unbounded hold; no output changes while out_valid & ~out_ready.
- rst in any state, including mid-MUL, aborts the operation and restores reset values on the next edge; the partial product is discarded.
- Operand and opcode are sampled only at accept; later changes are ignored.

## Configuration
- `ALU_ACC_FLAGS_EN` defined: out_carry, out_zero and out_ovf ports and flag registers exist as specified.
- Undefined: the three flag ports and their registers are removed; mul_c is removed. Accumulator behaviour and latency are unchanged.

## Structure
- Shared package/header `alu_pkg`: opcode constants OP_LOAD=2'b00, OP_ADD=2'b01, OP_SUB=2'b10, OP_MUL=2'b11; state encoding IDLE/MUL_LOOP/RESP; data width constant 4.
- Sub-module: one instance of the existing `adder_4b`. The control FSM, counter and registers stay in `alu_acc_4b`.

## Test plan
- Reset: assert rst 2 cycles -> out_acc=0, out_valid=0, in_ready=1, all flags 0.
- LOAD 9, ADD 9 -> out_acc=2, carry=1, ovf=1, zero=0, out_valid one cycle after accept.
- LOAD 3, SUB 5 -> acc=14, carry=0, ovf=0; then SUB 14 -> acc=0, zero=1, carry=1.
- LOAD 3, MUL 5 -> acc=15, carry=0, out_valid exactly 7 cycles after accept, in_ready=0 throughout; then MUL 2 -> acc=14, carry=1; then MUL 0 -> acc=0 after 2 cycles.
- Backpressure: out_ready=0 for 4 cycles in RESP -> out_valid, out_acc and flags stable, in_ready=0; raising out_ready completes the handshake, with in_ready=1 on the next cycle.
- LOAD 7, MUL 9, assert rst after 3 loop cycles -> acc=0, IDLE, out_valid never asserted for the aborted MUL.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, state and payload definitions for the 4-bit accumulator ALU.
package alu_pkg;

  localparam int unsigned DATA_W = 4;

  typedef logic [1:0] op_t;

  localparam op_t OP_LOAD = 2'b00;
  localparam op_t OP_ADD  = 2'b01;
  localparam op_t OP_SUB  = 2'b10;
  localparam op_t OP_MUL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_LOOP = 2'd1,
    RESP     = 2'd2
  } state_t;

  typedef struct packed {
    op_t               op;
    logic [DATA_W-1:0] operand;
  } cmd_t;

endpackage

// File: rtl/adder_4b.sv
// 4-bit ripple adder with carry in/out; shared by ADD, SUB and the MUL loop.
module adder_4b
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum_c,
  output logic              cout_c
);

  assign {cout_c, sum_c} = (DATA_W+1)'(a) + (DATA_W+1)'(b) + (DATA_W+1)'(cin);

endmodule

// File: rtl/alu_acc_4b.sv
// Accumulator stage: LOAD/ADD/SUB in one cycle, MUL by repeated addition.
// Flag ports and registers exist only when ALU_ACC_FLAGS_EN is defined.
module alu_acc_4b
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_operand,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_acc
`ifdef ALU_ACC_FLAGS_EN
  ,
  output logic              out_carry,
  output logic              out_zero,
  output logic              out_ovf
`endif
);

  localparam int unsigned MSB = DATA_W - 1;

  state_t            state, state_nxt;
  cmd_t              cmd_c;
  logic [DATA_W-1:0] mcand, prod, count;
  logic [DATA_W-1:0] add_a, add_b, add_sum;
  logic              add_cin, add_cout;

  assign cmd_c = '{op: in_op, operand: in_operand};

  // Adder operands: accumulator/operand when idle, product/multiplicand in the loop.
  always_comb begin
    add_a   = out_acc;
    add_b   = cmd_c.operand;
    add_cin = 1'b0;
    if (state == MUL_LOOP) begin
      add_a = prod;
      add_b = mcand;
    end else if (cmd_c.op == OP_SUB) begin
      add_b   = ~cmd_c.operand;
      add_cin = 1'b1;
    end
  end

  adder_4b u_adder (
    .a      (add_a),
    .b      (add_b),
    .cin    (add_cin),
    .sum_c  (add_sum),
    .cout_c (add_cout)
  );

`ifdef ALU_ACC_FLAGS_EN
  logic mul_c;
  logic add_ovf_c;

  assign add_ovf_c = (cmd_c.op == OP_SUB)
    ? ((out_acc[MSB] != cmd_c.operand[MSB]) && (add_sum[MSB] != out_acc[MSB]))
    : ((out_acc[MSB] == cmd_c.operand[MSB]) && (add_sum[MSB] != out_acc[MSB]));
`else
  logic unused_cout;
  assign unused_cout = add_cout;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (in_valid) state_nxt = (cmd_c.op == OP_MUL) ? MUL_LOOP : RESP;
      MUL_LOOP: if (count == '0) state_nxt = RESP;
      RESP:     if (out_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == RESP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_acc <= '0;
      mcand   <= '0;
      prod    <= '0;
      count   <= '0;
`ifdef ALU_ACC_FLAGS_EN
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
      out_ovf   <= 1'b0;
      mul_c     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            case (cmd_c.op)
              OP_LOAD: begin
                out_acc <= cmd_c.operand;
`ifdef ALU_ACC_FLAGS_EN
                out_carry <= 1'b0;
                out_ovf   <= 1'b0;
                out_zero  <= (cmd_c.operand == '0);
`endif
              end
              OP_ADD, OP_SUB: begin
                out_acc <= add_sum;
`ifdef ALU_ACC_FLAGS_EN
                out_carry <= add_cout;
                out_ovf   <= add_ovf_c;
                out_zero  <= (add_sum == '0);
`endif
              end
              default: begin
                mcand <= out_acc;
                count <= cmd_c.operand;
                prod  <= '0;
`ifdef ALU_ACC_FLAGS_EN
                mul_c <= 1'b0;
`endif
              end
            endcase
          end
        end
        MUL_LOOP: begin
          if (count == '0) begin
            out_acc <= prod;
`ifdef ALU_ACC_FLAGS_EN
            out_carry <= mul_c;
            out_ovf   <= 1'b0;
            out_zero  <= (prod == '0);
`endif
          end else begin
            prod  <= add_sum;
            count <= count - DATA_W'(1);
`ifdef ALU_ACC_FLAGS_EN
            mul_c <= mul_c | add_cout;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_acc_4b.sv
// Self-checking bench for alu_acc_4b: arithmetic-level model plus directed vectors.
module tb_alu_acc_4b;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_op = 2'b00;
  logic [3:0] in_operand = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_acc;
`ifdef ALU_ACC_FLAGS_EN
  logic       out_carry, out_zero, out_ovf;
`endif

  alu_acc_4b dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_operand (in_operand),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_acc    (out_acc)
`ifdef ALU_ACC_FLAGS_EN
    ,
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: whole-transaction arithmetic with a latency countdown.
  localparam int M_IDLE = 0, M_BUSY = 1, M_RESP = 2;
  int   mode = M_IDLE;
  int   m_left = 0;
  int   m_acc = 0, p_acc = 0;
  bit   m_c = 0, m_z = 0, m_o = 0, p_c = 0, p_o = 0;

  function automatic int sgn4(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  always @(posedge clk) begin
    int a, b, r, s;
    if (rst) begin
      mode = M_IDLE; m_acc = 0; m_c = 0; m_z = 0; m_o = 0;
    end else begin
      case (mode)
        M_IDLE: if (in_valid) begin
          a = m_acc; b = int'(in_operand);
          case (in_op)
            2'b00: begin p_acc = b; p_c = 0; p_o = 0; end
            2'b01: begin
              r = a + b; p_acc = r % 16; p_c = (r > 15);
              s = sgn4(a) + sgn4(b); p_o = (s > 7) || (s < -8);
            end
            2'b10: begin
              p_acc = (a - b + 16) % 16; p_c = (a >= b);
              s = sgn4(a) - sgn4(b); p_o = (s > 7) || (s < -8);
            end
            default: begin
              r = a * b; p_acc = r % 16; p_c = (r > 15); p_o = 0;
            end
          endcase
          if (in_op == 2'b11) begin
            mode = M_BUSY; m_left = b;
          end else begin
            m_acc = p_acc; m_c = p_c; m_o = p_o; m_z = (p_acc == 0); mode = M_RESP;
          end
        end
        M_BUSY: begin
          if (m_left == 0) begin
            m_acc = p_acc; m_c = p_c; m_o = p_o; m_z = (p_acc == 0); mode = M_RESP;
          end else begin
            m_left--;
          end
        end
        default: if (out_ready) mode = M_IDLE;
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 8'(in_ready), 8'(mode == M_IDLE));
      check("out_valid", 8'(out_valid), 8'(mode == M_RESP));
      check("out_acc", 8'(out_acc), 8'(m_acc));
`ifdef ALU_ACC_FLAGS_EN
      check("out_carry", 8'(out_carry), 8'(m_c));
      check("out_zero", 8'(out_zero), 8'(m_z));
      check("out_ovf", 8'(out_ovf), 8'(m_o));
`endif
    end
  end

  // Issue one command; hand-computed result, latency and flags {carry,zero,ovf}.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] opnd, input logic [3:0] e_acc,
                        input int e_lat, input logic [2:0] e_flags, input int bp);
    int lat;
    check("cmd_in_ready", 8'(in_ready), 8'd1);
    in_valid = 1'b1; in_op = op; in_operand = opnd;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 2'($urandom); in_operand = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 8'(lat), 8'(e_lat));
    check("res_acc", 8'(out_acc), 8'(e_acc));
    check("model_acc", 8'(m_acc), 8'(e_acc));
    check("model_flags", 8'({m_c, m_z, m_o}), 8'(e_flags));
`ifdef ALU_ACC_FLAGS_EN
    check("res_flags", 8'({out_carry, out_zero, out_ovf}), 8'(e_flags));
`endif
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 8'(out_valid), 8'd1);
      check("bp_acc", 8'(out_acc), 8'(e_acc));
      check("bp_in_ready", 8'(in_ready), 8'd0);
`ifdef ALU_ACC_FLAGS_EN
      check("bp_flags", 8'({out_carry, out_zero, out_ovf}), 8'(e_flags));
`endif
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_in_ready", 8'(in_ready), 8'd1);
    check("post_out_valid", 8'(out_valid), 8'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    check("rst_acc", 8'(out_acc), 8'd0);
    check("rst_valid", 8'(out_valid), 8'd0);
    check("rst_ready", 8'(in_ready), 8'd1);
`ifdef ALU_ACC_FLAGS_EN
    check("rst_flags", 8'({out_carry, out_zero, out_ovf}), 8'd0);
`endif
    @(posedge clk); #1;

    do_cmd(OP_LOAD, 4'd9,  4'd9,  1, 3'b000, 0);
    do_cmd(OP_ADD,  4'd9,  4'd2,  1, 3'b101, 0);
    do_cmd(OP_LOAD, 4'd3,  4'd3,  1, 3'b000, 0);
    do_cmd(OP_SUB,  4'd5,  4'd14, 1, 3'b000, 0);
    do_cmd(OP_SUB,  4'd14, 4'd0,  1, 3'b110, 0);
    do_cmd(OP_LOAD, 4'd7,  4'd7,  1, 3'b000, 0);
    do_cmd(OP_ADD,  4'd1,  4'd8,  1, 3'b001, 0);
    do_cmd(OP_SUB,  4'd1,  4'd7,  1, 3'b101, 0);
    do_cmd(OP_LOAD, 4'd3,  4'd3,  1, 3'b000, 0);
    do_cmd(OP_MUL,  4'd5,  4'd15, 7, 3'b000, 0);
    do_cmd(OP_MUL,  4'd2,  4'd14, 4, 3'b100, 4);
    do_cmd(OP_MUL,  4'd0,  4'd0,  2, 3'b010, 0);
    do_cmd(OP_LOAD, 4'd0,  4'd0,  1, 3'b010, 0);

    // Abort a multiply partway through the loop.
    do_cmd(OP_LOAD, 4'd7,  4'd7,  1, 3'b000, 0);
    in_valid = 1'b1; in_op = OP_MUL; in_operand = 4'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_acc", 8'(out_acc), 8'd0);
    check("abort_ready", 8'(in_ready), 8'd1);
    check("abort_valid", 8'(out_valid), 8'd0);
    repeat (12) @(posedge clk);
    #1;
    check("abort_quiet", 8'(out_valid), 8'd0);
    do_cmd(OP_ADD,  4'd5,  4'd5,  1, 3'b000, 0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
